adder_seq: RTL



---
 rtl/adder_pkg.sv | 7 +
 rtl/adder_seq_if.sv | 20 ++
 rtl/adder_chunk.sv | 24 ++
 rtl/adder_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder/subtractor.
package adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;
endpackage

// File: rtl/adder_seq_if.sv
// Launch/result bundle for adder_seq; the requester drives the master side.
interface adder_seq_if
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
   modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the caller can form signed overflow on the final chunk.
module adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);
   logic [CHUNK:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = c[CHUNK];
   assign cmsb_o = c[CHUNK-1];
endmodule

// File: rtl/adder_seq.sv
// Chunk-serial WIDTH-bit add/sub: one CHUNK-bit ripple adder reused for
// NCHUNK cycles, LSB chunk first, with start/busy/done handshake.
module adder_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic        clk,
   input  logic        rst,
   adder_seq_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
      $error("adder_seq: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d, ovf_q, ovf_d;

   logic [CHUNK-1:0]  csum;
   logic              cco, cmsb;
   logic [WIDTH-1:0]  res_shift;

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (a_q[CHUNK-1:0]),
      .b_i    (b_q[CHUNK-1:0]),
      .cin_i  (carry_q),
      .sum_o  (csum),
      .cout_o (cco),
      .cmsb_o (cmsb)
   );

   // Partial results build up MSB-first in acc_q so that after the last chunk
   // {csum, acc_q} is the full word in place; sum_q alone is externally visible.
   if (NCHUNK == 1) begin : g_one
      assign res_shift = csum;
   end else begin : g_multi
      logic [WIDTH-CHUNK-1:0] acc_q;
      always_ff @(posedge clk) begin
         if (rst)                  acc_q <= '0;
         else if (state_q == RUN)  acc_q <= res_shift[WIDTH-1:CHUNK];
      end
      assign res_shift = {csum, acc_q};
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = cco;
            if (idx_q == IDXW'(NCHUNK - 1)) begin
               sum_d   = res_shift;
               cout_d  = cco;
               ovf_d   = cmsb ^ cco;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule
